// File: rtl/note_sequencer_pkg.sv
// note_sequencer_pkg: shared state encoding, field widths and rest code
package note_sequencer_pkg;
    localparam int NOTE_W  = 4;
    localparam int OCT_W   = 2;
    localparam int ENTRY_W = NOTE_W + OCT_W;
    localparam logic [NOTE_W-1:0] REST = 4'd0;
    typedef enum logic [1:0] {IDLE, PLAY_NOTE, PLAY_GAP} state_t;
endpackage

// File: rtl/tick_timer.sv
// tick_timer: free counter with terminal-count pulse, shared by note and gap phases
// Ports: clk/reset (async active-low); clear forces 0; en advances; term is the
// last count of the phase; done pulses while en and count == term.
module tick_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             done
);
    logic [CNT_W-1:0] count;

    assign done = en & (count == term);

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            count <= '0;
        else if (clear || done)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: records note presses into a buffer and replays them at a fixed tempo
// Ports: clk, reset (async active-low); load_n falling edge records {octave_in, note_in};
// playback rising edge starts/aborts replay; clear empties the buffer while idle.
// Outputs note_out/octave_out/note_valid drive the datapath; busy, full, rec_count
// and play_idx report status.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4,
    parameter int NOTE_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 1_250_000,
    parameter int CNT_W      = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_n,
    input  logic              playback,
    input  logic              clear,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [OCT_W-1:0]  octave_in,
    output logic [NOTE_W-1:0] note_out,
    output logic [OCT_W-1:0]  octave_out,
    output logic              note_valid,
    output logic              busy,
    output logic              full,
    output logic [ADDR_W:0]   rec_count,
    output logic [ADDR_W-1:0] play_idx
);
    localparam logic [CNT_W-1:0] NOTE_TC = CNT_W'(NOTE_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_TICKS - 1);
    localparam logic [ADDR_W:0]  FULL_V  = (ADDR_W + 1)'(DEPTH);

    state_t              state, next_state;
    logic [ADDR_W-1:0]   next_idx;
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [ENTRY_W-1:0]  entry_q;
    logic                load_n_q, playback_q;
    logic                press, req, write, last, timer_done;

    assign press = load_n_q & ~load_n;
    assign req   = ~playback_q & playback;
    assign full  = rec_count == FULL_V;
    assign last  = {1'b0, play_idx} == rec_count - 1'b1;
    // Recording only while idle; clear and a playback request both outrank a press.
    assign write = (state == IDLE) & press & ~req & ~clear & ~full;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            load_n_q   <= 1'b1;
            playback_q <= 1'b0;
        end else begin
            load_n_q   <= load_n;
            playback_q <= playback;
        end

    tick_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .clear (state == IDLE),
        .en    (state != IDLE),
        .term  (state == PLAY_NOTE ? NOTE_TC : GAP_TC),
        .done  (timer_done)
    );

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state    <= IDLE;
            play_idx <= '0;
        end else begin
            state    <= next_state;
            play_idx <= next_idx;
        end

    always_comb begin
        next_state = state;
        next_idx   = play_idx;
        case (state)
            IDLE:
                if (!clear && req && rec_count != '0) begin
                    next_state = PLAY_NOTE;
                    next_idx   = '0;
                end
            PLAY_NOTE:
                if (req) begin
                    next_state = IDLE;
                    next_idx   = '0;
                end else if (timer_done)
                    next_state = PLAY_GAP;
            PLAY_GAP:
                if (req) begin
                    next_state = IDLE;
                    next_idx   = '0;
                end else if (timer_done) begin
                    next_state = last ? IDLE : PLAY_NOTE;
                    next_idx   = last ? '0 : play_idx + 1'b1;
                end
            default: begin
                next_state = IDLE;
                next_idx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            rec_count <= '0;
        else if (state == IDLE && clear)
            rec_count <= '0;
        else if (write)
            rec_count <= rec_count + 1'b1;

    always_ff @(posedge clk)
        if (write)
            mem[rec_count[ADDR_W-1:0]] <= {octave_in, note_in};

    // Read is addressed by the next index so the note lands with the PLAY_NOTE state.
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            entry_q <= '0;
        else
            entry_q <= next_state == PLAY_NOTE ? mem[next_idx] : {{OCT_W{1'b0}}, REST};

    always_comb begin
        note_valid = state == PLAY_NOTE;
        busy       = state != IDLE;
        note_out   = entry_q[NOTE_W-1:0];
        octave_out = entry_q[ENTRY_W-1:NOTE_W];
    end
endmodule
